sprite_palette_pipe: RTL and testbench
======================================

SPRITE_PALETTE_PIPE -- requirements
Module: sprite_palette_pipe

Interface
REQ-001 Parameter IDX_W, default 4, colour-index width; each palette holds 2**IDX_W entries.
REQ-002 Parameter NUM_PAL, default 4, palette count, power of two; PSEL_W = clog2(NUM_PAL), minimum 1.
REQ-003 Port Clk  in  1  sole clock, rising edge.
REQ-004 Port Reset_n  in  1  asynchronous active-low reset.
REQ-005 Port in_valid  in  1  lookup request this cycle.
REQ-006 Port pal_sel  in  PSEL_W  palette used for the lookup.
REQ-007 Port data_in  in  IDX_W  colour index for the lookup.
REQ-008 Port wr_en  in  1  palette entry write strobe.
REQ-009 Port wr_pal / wr_idx / wr_rgb  in  PSEL_W / IDX_W / 24  write target and RGB value (R[23:16], G[15:8], B[7:0]).
REQ-010 Port ready  out  1  high once default palettes are loaded.
REQ-011 Port out_valid  out  1  red/green/blue/transparent are valid.
REQ-012 Port red_data / green_data / blue_data  out  8 each  looked-up colour.
REQ-013 Port transparent  out  1  output colour equals the key colour.

Function
REQ-014 FSM states INIT and RUN; reset enters INIT with load counter 0.
REQ-015 INIT writes DEFAULT_PAL[idx] into entry idx of palette p, one entry per cycle, for NUM_PAL*2**IDX_W cycles; entries idx >= 13 receive KEY_RGB.
REQ-016 After the final INIT write, the FSM moves to RUN and ready asserts on the next cycle; RUN is held until reset.
REQ-017 In INIT, in_valid and wr_en are ignored; no lookup enters the pipeline.
REQ-018 In RUN, a lookup accepted in cycle N produces out_valid=1 with its colour in cycle N+2; throughput is one lookup per cycle; no backpressure.
REQ-019 The pipeline has two stages: stage 1 registers pal_sel/data_in/in_valid; stage 2 registers the palette read data and valid.
REQ-020 out_valid=0 causes colour outputs to hold their previous values.
REQ-021 In RUN, wr_en=1 updates entry (wr_pal, wr_idx) at the clock edge.
REQ-022 A lookup whose stage-2 read reads the entry being written in the same cycle returns the old value; the next read of that entry returns the new value.
REQ-023 Back-to-back writes to the same entry are applied in order; the last write wins.

Reset
REQ-024 Reset_n low asynchronously clears out_valid, ready, the colour outputs, transparent, pipeline valid bits and the load counter, and forces INIT.
REQ-025 Reset asserted mid-INIT or mid-stream discards all in-flight lookups; palettes are reloaded from defaults, and runtime writes are lost.

Configuration
REQ-026 With macro SPRITE_PAL_TRANSP_KEY_EN defined, transparent is registered alongside the colour and is 1 iff the 24-bit result equals KEY_RGB.
REQ-027 Without the macro, transparent is constant 0 and no comparator is built.

Structure
REQ-028 Package sprite_palette_pkg holds KEY_RGB = 24'hFE06FF, the rgb_t struct (r, g, b bytes), and DEFAULT_PAL, a 13-entry rgb_t table:
0D1000 252108 2F2013 3D210E 5B301B 6E381C 8F4D2A 8A4D21 CB6C3D B46E27 D88E46 FE06FF B27721.
REQ-029 Storage is one sub-module, palette_ram (one sync write port, one sync read port, depth NUM_PAL*2**IDX_W, address {pal, idx}); sprite_palette_pipe owns the FSM, pipeline and key compare.

Verification
REQ-030 Release reset, hold in_valid=1 -> ready rises after exactly 64 INIT cycles plus 1 (default parameters); out_valid stays 0 throughout INIT.
REQ-031 RUN, pal_sel=2, data_in=8 at cycle N -> cycle N+2: out_valid=1, RGB=CB/6C/3D, transparent=0.
REQ-032 RUN, data_in=4'hB then 4'hF on consecutive cycles -> two consecutive outputs FE/06/FF, both transparent=1 with the macro and 0 without it.
REQ-033 Write wr_pal=1, wr_idx=3, wr_rgb=123456 in the same cycle the (1,3) lookup is in stage 2 -> that lookup returns 3D210E; the next (1,3) lookup returns 12/34/56.
REQ-034 Assert Reset_n=0 with two lookups in flight -> out_valid=0 and ready=0 immediately; after reload, (1,3) returns 3D210E.

Source files
------------

// File: rtl/sprite_palette_pkg.sv
// sprite_palette_pkg: shared types and constants for the sprite palette pipeline.
//   rgb_t        - packed 24-bit colour, r in [23:16], g in [15:8], b in [7:0]
//   state_e      - loader/run FSM state
//   KEY_RGB      - transparency key colour
//   DEFAULT_PAL  - default contents for palette entries 0..12
//   default_rgb  - reset-time contents of any entry index (KEY_RGB above the table)
package sprite_palette_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    localparam logic [23:0] KEY_RGB = 24'hFE06FF;

    localparam int unsigned NUM_DEFAULT = 13;

    localparam rgb_t DEFAULT_PAL [NUM_DEFAULT] = '{
        rgb_t'(24'h0D1000), rgb_t'(24'h252108), rgb_t'(24'h2F2013), rgb_t'(24'h3D210E),
        rgb_t'(24'h5B301B), rgb_t'(24'h6E381C), rgb_t'(24'h8F4D2A), rgb_t'(24'h8A4D21),
        rgb_t'(24'hCB6C3D), rgb_t'(24'hB46E27), rgb_t'(24'hD88E46), rgb_t'(24'hFE06FF),
        rgb_t'(24'hB27721)
    };

    // Entries past the end of the default table load as the key colour.
    function automatic rgb_t default_rgb(input int unsigned idx);
        if (idx < NUM_DEFAULT) begin
            return DEFAULT_PAL[4'(idx)];
        end
        return rgb_t'(KEY_RGB);
    endfunction

endpackage

// File: rtl/sprite_palette_pipe_if.sv
// sprite_palette_pipe_if: lookup, write and result signals of the palette pipeline.
//   master - request side: drives in_valid/pal_sel/data_in and wr_en/wr_pal/wr_idx/wr_rgb,
//            observes ready/out_valid/red_data/green_data/blue_data/transparent
//   slave  - the pipeline itself (opposite directions)
interface sprite_palette_pipe_if #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned NUM_PAL = 4
);
    localparam int unsigned PSEL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;

    logic              in_valid;
    logic [PSEL_W-1:0] pal_sel;
    logic [IDX_W-1:0]  data_in;

    logic              wr_en;
    logic [PSEL_W-1:0] wr_pal;
    logic [IDX_W-1:0]  wr_idx;
    logic [23:0]       wr_rgb;

    logic              ready;
    logic              out_valid;
    logic [7:0]        red_data;
    logic [7:0]        green_data;
    logic [7:0]        blue_data;
    logic              transparent;

    modport master (
        output in_valid, pal_sel, data_in, wr_en, wr_pal, wr_idx, wr_rgb,
        input  ready, out_valid, red_data, green_data, blue_data, transparent
    );

    modport slave (
        input  in_valid, pal_sel, data_in, wr_en, wr_pal, wr_idx, wr_rgb,
        output ready, out_valid, red_data, green_data, blue_data, transparent
    );

endinterface

// File: rtl/palette_ram.sv
// palette_ram: palette storage, one synchronous write port and one synchronous read port.
//   Clk, Reset_n        - clock, async active-low reset (clears the read register only)
//   wr_en/wr_addr/wr_data - write port, applied at the rising edge
//   rd_en/rd_addr       - read request; rd_data updates at the edge when rd_en is high
//                         and otherwise holds
// A read and a write to the same address at one edge returns the old word.
module palette_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 24
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sprite_palette_pipe.sv
// sprite_palette_pipe: palette lookup pipeline with default-palette loader.
//   Clk      - clock, rising edge
//   Reset_n  - asynchronous active-low reset; forces a full palette reload
//   bus      - sprite_palette_pipe_if.slave: lookup request (in_valid/pal_sel/data_in),
//              entry write (wr_en/wr_pal/wr_idx/wr_rgb), ready, and the looked-up colour
//              (out_valid/red_data/green_data/blue_data/transparent) two cycles later.
// After reset the FSM spends one cycle per palette entry loading defaults, then runs.
// Optional feature: define SPRITE_PAL_TRANSP_KEY_EN to drive transparent when the result
// equals KEY_RGB; otherwise transparent is tied low.
module sprite_palette_pipe
    import sprite_palette_pkg::*;
#(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned NUM_PAL = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    sprite_palette_pipe_if.slave  bus
);

    localparam int unsigned PSEL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
    localparam int unsigned ADDR_W = PSEL_W + IDX_W;
    localparam int unsigned DEPTH  = NUM_PAL * (2 ** IDX_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef SPRITE_PAL_TRANSP_KEY_EN
    // Bit 24 holds the key-match flag, computed on the write path so it is read out and
    // registered together with the colour.
    localparam int unsigned DATA_W = 25;
`else
    localparam int unsigned DATA_W = 24;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] load_cnt_q;
    logic              ready_q;

    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              out_valid_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [23:0]       ram_wdata;
    logic [DATA_W-1:0] ram_wword;
    logic [DATA_W-1:0] rd_word;

    // Loader / run FSM. ready follows the RUN state by one cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StInit;
            load_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    load_cnt_q <= load_cnt_q + ADDR_W'(1);
                    if (load_cnt_q == LAST_ADDR) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // Write port: the loader owns it during INIT, runtime writes only in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = load_cnt_q;
        ram_wdata = default_rgb(32'(load_cnt_q[IDX_W-1:0]));
        if (state_q == StInit) begin
            ram_we = 1'b1;
        end else if (bus.wr_en) begin
            ram_we    = 1'b1;
            ram_waddr = {bus.wr_pal, bus.wr_idx};
            ram_wdata = bus.wr_rgb;
        end
    end

`ifdef SPRITE_PAL_TRANSP_KEY_EN
    assign ram_wword = {ram_wdata == KEY_RGB, ram_wdata};
`else
    assign ram_wword = ram_wdata;
`endif

    // Stage 1: capture the request.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
        end else begin
            s1_valid_q <= (state_q == StRun) && bus.in_valid;
            if ((state_q == StRun) && bus.in_valid) begin
                s1_addr_q <= {bus.pal_sel, bus.data_in};
            end
        end
    end

    // Stage 2: the RAM read register holds the colour; it only loads on a valid request,
    // so outputs hold while out_valid is low.
    palette_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_palette_ram (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wword),
        .rd_en   (s1_valid_q),
        .rd_addr (s1_addr_q),
        .rd_data (rd_word)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.red_data   = rd_word[23:16];
    assign bus.green_data = rd_word[15:8];
    assign bus.blue_data  = rd_word[7:0];

`ifdef SPRITE_PAL_TRANSP_KEY_EN
    assign bus.transparent = rd_word[24];
`else
    assign bus.transparent = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_palette_pipe.sv
// tb_sprite_palette_pipe: directed stimulus with a scoreboard queue; a negedge monitor pops
// and checks every out_valid beat against the expected colour pushed at issue time.
module tb_sprite_palette_pipe;
    import sprite_palette_pkg::*;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned NUM_PAL = 4;
    localparam int unsigned PSEL_W  = 2;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b1;

    always #5 Clk = ~Clk;

    sprite_palette_pipe_if #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL)) bus ();

    sprite_palette_pipe #(
        .IDX_W   (IDX_W),
        .NUM_PAL (NUM_PAL)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        transp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic logic key_exp(input logic [23:0] rgb);
`ifdef SPRITE_PAL_TRANSP_KEY_EN
        return rgb == 24'hFE06FF;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor / scoreboard.
    always @(negedge Clk) begin
        if (bus.out_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got rgb=%06h, required no output",
                         {bus.red_data, bus.green_data, bus.blue_data});
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.red_data, bus.green_data, bus.blue_data} !== mon_e.rgb ||
                    bus.transparent !== mon_e.transp) begin
                    fails++;
                    $display("FAIL %s: got rgb=%06h transp=%0b, required rgb=%06h transp=%0b",
                             mon_e.name, {bus.red_data, bus.green_data, bus.blue_data},
                             bus.transparent, mon_e.rgb, mon_e.transp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic lookup(input int p, input int i, input logic [23:0] rgb, input string name);
        bus.in_valid = 1'b1;
        bus.pal_sel  = PSEL_W'(p);
        bus.data_in  = IDX_W'(i);
        exp_q.push_back('{rgb, key_exp(rgb), name});
        @(posedge Clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic write_entry(input int p, input int i, input logic [23:0] rgb);
        bus.wr_en  = 1'b1;
        bus.wr_pal = PSEL_W'(p);
        bus.wr_idx = IDX_W'(i);
        bus.wr_rgb = rgb;
        @(posedge Clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Counts rising edges after release until ready is seen; also flags out_valid in INIT.
    task automatic wait_ready(output int cyc, output logic saw_ov);
        cyc    = 0;
        saw_ov = 1'b0;
        while (cyc < 200 && bus.ready !== 1'b1) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (bus.out_valid === 1'b1 && bus.ready !== 1'b1) saw_ov = 1'b1;
        end
    endtask

    initial begin
        int   cyc;
        logic saw_ov;
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic saw_ov;

        bus.in_valid = 1'b0;
        bus.pal_sel  = '0;
        bus.data_in  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_pal   = '0;
        bus.wr_idx   = '0;
        bus.wr_rgb   = '0;

        #1 Reset_n = 1'b0;
        #6;
        check("reset_ready", bus.ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_rgb", {bus.red_data, bus.green_data, bus.blue_data}, 0);
        repeat (2) @(posedge Clk);

        // Release with a lookup held through INIT: none may be accepted before RUN.
        @(negedge Clk);
        Reset_n      = 1'b1;
        bus.in_valid = 1'b1;
        bus.pal_sel  = 2'd0;
        bus.data_in  = 4'd0;
        wait_ready(cyc, saw_ov);
        check("init_ready_cycles", cyc, 65);
        check("init_out_valid", saw_ov, 0);
        bus.in_valid = 1'b0;
        // The held request is accepted in the single RUN cycle before ready rises.
        if (bus.ready === 1'b1) exp_q.push_back('{24'h0D1000, 1'b0, "held_lookup_0_0"});
        drain("drain_init");

        lookup(2, 8, 24'hCB6C3D, "p2_i8");
        drain("drain_p2_i8");
        repeat (2) @(posedge Clk);
        #1;
        check("hold_out_valid", bus.out_valid, 0);
        check("hold_rgb", {bus.red_data, bus.green_data, bus.blue_data}, 24'hCB6C3D);

        lookup(2, 11, 24'hFE06FF, "key_idx_b");
        lookup(2, 15, 24'hFE06FF, "key_idx_f");
        lookup(3, 12, 24'hB27721, "p3_i12");
        lookup(1, 5, 24'h6E381C, "p1_i5");
        lookup(0, 13, 24'hFE06FF, "p0_i13");
        drain("drain_defaults");

        // Write lands on the same edge as the first (1,3) lookup's RAM read.
        bus.in_valid = 1'b1;
        bus.pal_sel  = 2'd1;
        bus.data_in  = 4'd3;
        exp_q.push_back('{24'h3D210E, 1'b0, "collide_old"});
        @(posedge Clk);
        #1;
        bus.wr_en  = 1'b1;
        bus.wr_pal = 2'd1;
        bus.wr_idx = 4'd3;
        bus.wr_rgb = 24'h123456;
        exp_q.push_back('{24'h123456, 1'b0, "collide_new"});
        @(posedge Clk);
        #1;
        bus.wr_en    = 1'b0;
        bus.in_valid = 1'b0;
        drain("drain_collide");

        write_entry(2, 5, 24'hAAAAAA);
        write_entry(2, 5, 24'hBBBBBB);
        lookup(2, 5, 24'hBBBBBB, "last_write_wins");
        write_entry(0, 2, 24'hFE06FF);
        lookup(0, 2, 24'hFE06FF, "written_key");
        drain("drain_writes");

        // Two lookups in flight, then asynchronous reset: both are discarded.
        bus.in_valid = 1'b1;
        bus.pal_sel  = 2'd1;
        bus.data_in  = 4'd4;
        @(posedge Clk);
        #1;
        bus.pal_sel  = 2'd2;
        bus.data_in  = 4'd6;
        @(posedge Clk);
        #1;
        bus.in_valid = 1'b0;
        Reset_n      = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_ready", bus.ready, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        // A write attempted during INIT must be ignored.
        bus.wr_en  = 1'b1;
        bus.wr_pal = 2'd1;
        bus.wr_idx = 4'd3;
        bus.wr_rgb = 24'hABCDEF;
        repeat (30) @(posedge Clk);
        #1;
        bus.wr_en = 1'b0;
        wait_ready(cyc, saw_ov);
        check("reload_ready", bus.ready, 1);
        lookup(1, 3, 24'h3D210E, "reload_1_3");
        drain("drain_reload");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
